booth_multiplier: RTL and testbench

Sequential signed 16x16 Booth multiplier producing a 32-bit two's-complement product. Operands are captured with a load strobe. A second strobe starts the partial-product iteration, which retires one Booth step per clock. It is a standalone arithmetic datapath plus a small controller, used wherever a low-area multi-cycle signed multiply is acceptable.

---
 rtl/booth_pkg.sv | 46 ++++
 rtl/booth_multiplier_recoder.sv | 27 ++
 rtl/booth_multiplier.sv | 109 ++++++++++
 tb/tb_booth_multiplier.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared widths, step counts, FSM states and Booth recoding for booth_multiplier.
// Define BOOTH_RADIX4_EN to select radix-4 modified Booth (8 steps) instead of radix-2 (16 steps).
package booth_pkg;

  localparam int OP_W     = 16;
  localparam int PROD_W   = 32;
  localparam int STEPS_R2 = 16;
  localparam int STEPS_R4 = 8;

`ifdef BOOTH_RADIX4_EN
  localparam int NUM_STEPS = STEPS_R4;
  localparam int GRP_W     = 3;
  localparam int ACC_W     = 18;
  localparam int SHIFT     = 2;
`else
  localparam int NUM_STEPS = STEPS_R2;
  localparam int GRP_W     = 2;
  localparam int ACC_W     = 17;
  localparam int SHIFT     = 1;
`endif

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Returns the Booth digit as a 3-bit two's-complement value in -2..+2.
  function automatic logic [2:0] booth_recode(input logic [GRP_W-1:0] grp);
    logic [2:0] digit;
    digit = 3'b000;
`ifdef BOOTH_RADIX4_EN
    case (grp)
      3'b001, 3'b010: digit = 3'b001;
      3'b011:         digit = 3'b010;
      3'b100:         digit = 3'b110;
      3'b101, 3'b110: digit = 3'b111;
      default:        digit = 3'b000;
    endcase
`else
    case (grp)
      2'b01:   digit = 3'b001;
      2'b10:   digit = 3'b111;
      default: digit = 3'b000;
    endcase
`endif
    return digit;
  endfunction

endpackage

// File: rtl/booth_multiplier_recoder.sv
// Combinational Booth recoder: maps a multiplier bit group and the multiplicand
// to the signed addend applied to the accumulator this step.
module booth_recoder
  import booth_pkg::*;
(
  input  logic [GRP_W-1:0] grp,
  input  logic [OP_W-1:0]  m,
  output logic [ACC_W-1:0] addend
);

  logic [2:0]       digit;
  logic [ACC_W-1:0] m_ext;

  always_comb begin
    digit  = booth_recode(grp);
    m_ext  = {{(ACC_W-OP_W){m[OP_W-1]}}, m};
    addend = '0;
    case (digit)
      3'b001:  addend = m_ext;
      3'b111:  addend = -m_ext;
      3'b010:  addend = m_ext << 1;
      3'b110:  addend = -(m_ext << 1);
      default: addend = '0;
    endcase
  end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed 16x16 Booth multiplier: ld captures operands, ld_PP starts the
// iteration, one Booth step per clock. BOOTH_RADIX4_EN selects radix-4 (8 steps).
module booth_multiplier
  import booth_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [OP_W-1:0]   in_A,
  input  logic [OP_W-1:0]   in_B,
  input  logic              ld,
  input  logic              ld_PP,
  output logic [PROD_W-1:0] product
);

  state_t              state_q, state_d;
  logic [OP_W-1:0]     m_q, m_d;
  logic [OP_W-1:0]     b_q, b_d;
  logic [OP_W-1:0]     q_q, q_d;
  logic [ACC_W-1:0]    acc_q, acc_d;
  logic                q1_q, q1_d;
  logic [4:0]          count_q, count_d;
  logic [PROD_W-1:0]   product_q, product_d;

  logic [GRP_W-1:0]    grp;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W+OP_W:0] shifted;
  logic                last_step;
  logic                start;

  assign grp       = {q_q[GRP_W-2:0], q1_q};
  assign sum       = acc_q + addend;
  // Arithmetic shift of the whole {ACC,Q,Q_1} chain keeps the ACC sign.
  assign shifted   = $signed({sum, q_q, q1_q}) >>> SHIFT;
  assign last_step = (count_q == 5'(NUM_STEPS - 1));
  assign start     = ld_PP && !ld && (state_q != RUN);
  assign product   = product_q;

  booth_recoder u_recoder (
    .grp    (grp),
    .m      (m_q),
    .addend (addend)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (ld) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (ld_PP) state_d = RUN;
        RUN:        if (last_step) state_d = DONE;
        default:    state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    m_d       = m_q;
    b_d       = b_q;
    q_d       = q_q;
    acc_d     = acc_q;
    q1_d      = q1_q;
    count_d   = count_q;
    product_d = product_q;
    if (ld) begin
      m_d       = in_A;
      b_d       = in_B;
      product_d = '0;
    end else if (start) begin
      acc_d   = '0;
      q_d     = b_q;
      q1_d    = 1'b0;
      count_d = '0;
    end else if (state_q == RUN) begin
      acc_d   = shifted[ACC_W+OP_W:OP_W+1];
      q_d     = shifted[OP_W:1];
      q1_d    = shifted[0];
      count_d = count_q + 5'd1;
      if (last_step) product_d = {acc_d[OP_W-1:0], q_d};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q       <= '0;
      b_q       <= '0;
      q_q       <= '0;
      acc_q     <= '0;
      q1_q      <= 1'b0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      m_q       <= m_d;
      b_q       <= b_d;
      q_q       <= q_d;
      acc_q     <= acc_d;
      q1_q      <= q1_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier.sv
// Scoreboard bench for booth_multiplier; honours BOOTH_RADIX4_EN for the expected latency.
module tb_booth_multiplier;

`ifdef BOOTH_RADIX4_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  localparam logic [15:0] A_T [8] = '{16'h0003, 16'h7FFF, 16'h8000, 16'h8000,
                                      16'h0000, 16'h8000, 16'hFFFF, 16'h7FFF};
  localparam logic [15:0] B_T [8] = '{16'hFFFE, 16'h7FFF, 16'h8000, 16'h0001,
                                      16'h8000, 16'h0000, 16'hFFFF, 16'h8000};
  localparam logic [31:0] P_T [8] = '{32'hFFFFFFFA, 32'h3FFF0001, 32'h40000000, 32'hFFFF8000,
                                      32'h00000000, 32'h00000000, 32'h00000001, 32'hC0008000};

  logic        clk = 1'b0;
  logic        reset, ld, ld_PP;
  logic [15:0] in_A, in_B;
  logic [31:0] product;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] sb[$];
  logic [31:0] exp_v;

  always #5 clk = ~clk;

  booth_multiplier dut (
    .clk     (clk),
    .reset   (reset),
    .in_A    (in_A),
    .in_B    (in_B),
    .ld      (ld),
    .ld_PP   (ld_PP),
    .product (product)
  );

  function automatic logic [31:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p;
  endfunction

  // Drivers are called at a falling edge and consume exactly one rising edge.
  task automatic load(input logic [15:0] a, input logic [15:0] b);
    in_A = a; in_B = b; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; in_A = 16'($urandom); in_B = 16'($urandom);
  endtask

  task automatic start_pp();
    ld_PP = 1'b1;
    @(negedge clk);
    ld_PP = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; ld = 1'b0; ld_PP = 1'b0; in_A = 16'hFFFF; in_B = 16'hFFFF;
    @(negedge clk);
    idle(2);
    reset = 1'b0;
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL reset: got %h expected %h", product, 32'h0);
    end
  endtask

  task automatic test_basic();
    load(16'h8981, 16'h8555);
    idle(2);
    start_pp();
    sb.push_back(32'h38C7ACD5);
    idle(LAT - 1);
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL basic_early: got %h expected %h", product, 32'h0);
    end
    idle(1);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL basic: got %h expected %h", product, exp_v);
    end
    $display("basic: A=8981 B=8555 product=%h", product);
  endtask

  task automatic test_directed();
    for (int i = 0; i < 8; i++) begin
      load(A_T[i], B_T[i]);
      start_pp();
      sb.push_back(P_T[i]);
      idle(LAT);
      exp_v = sb.pop_front();
      n_vec++;
      if (product !== exp_v) begin
        n_miss++;
        $display("FAIL directed[%0d] A=%h B=%h: got %h expected %h", i, A_T[i], B_T[i], product, exp_v);
      end
      $display("directed: A=%h B=%h product=%h", A_T[i], B_T[i], product);
    end
  endtask

  task automatic test_abort();
    load(16'h1234, 16'h5678);
    start_pp();
    idle(6);
    load(16'h0002, 16'h0005);
    idle(LAT);
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL abort: got %h expected %h", product, 32'h0);
    end
    start_pp();
    sb.push_back(32'h0000000A);
    idle(LAT);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL after_abort: got %h expected %h", product, exp_v);
    end
    idle(3);
    n_vec++;
    if (product !== 32'h0000000A) begin
      n_miss++; $display("FAIL hold: got %h expected %h", product, 32'h0000000A);
    end
    $display("abort: reloaded 2*5 product=%h", product);
  endtask

  task automatic test_ld_and_pp();
    in_A = 16'h0003; in_B = 16'h0003; ld = 1'b1; ld_PP = 1'b1;
    @(negedge clk);
    ld = 1'b0; ld_PP = 1'b0;
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL ld_prio_clear: got %h expected %h", product, 32'h0);
    end
    idle(LAT + 2);
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL ld_prio_norun: got %h expected %h", product, 32'h0);
    end
    start_pp();
    sb.push_back(32'h00000009);
    idle(LAT);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL ld_prio_run: got %h expected %h", product, exp_v);
    end
    $display("ld_and_pp: 3*3 product=%h", product);
  endtask

  task automatic test_pp_in_run();
    load(16'h0007, 16'hFFF9);
    start_pp();
    sb.push_back(32'hFFFFFFCF);
    idle(3);
    start_pp();
    idle(LAT - 5);
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL pp_in_run_early: got %h expected %h", product, 32'h0);
    end
    idle(1);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL pp_in_run: got %h expected %h", product, exp_v);
    end
    $display("pp_in_run: 7*-7 product=%h", product);
  endtask

  task automatic test_restart_done();
    idle(4);
    n_vec++;
    if (product !== 32'hFFFFFFCF) begin
      n_miss++; $display("FAIL done_hold: got %h expected %h", product, 32'hFFFFFFCF);
    end
    start_pp();
    sb.push_back(32'hFFFFFFCF);
    idle(LAT - 1);
    n_vec++;
    if (product !== 32'hFFFFFFCF) begin
      n_miss++; $display("FAIL restart_run_hold: got %h expected %h", product, 32'hFFFFFFCF);
    end
    idle(1);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL restart: got %h expected %h", product, exp_v);
    end
    $display("restart_done: product=%h", product);
  endtask

  task automatic test_reset_mid_run();
    load(16'h7FFF, 16'h7FFF);
    start_pp();
    sb.push_back(32'h3FFF0001);
    idle(LAT);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL pre_reset: got %h expected %h", product, exp_v);
    end
    start_pp();
    idle(5);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL reset_mid_run: got %h expected %h", product, 32'h0);
    end
    idle(LAT + 2);
    n_vec++;
    if (product !== 32'h0) begin
      n_miss++; $display("FAIL reset_no_result: got %h expected %h", product, 32'h0);
    end
    // Operands were cleared by reset, so a bare start must multiply zeros.
    start_pp();
    sb.push_back(32'h0);
    idle(LAT);
    exp_v = sb.pop_front();
    n_vec++;
    if (product !== exp_v) begin
      n_miss++; $display("FAIL no_ld: got %h expected %h", product, exp_v);
    end
    $display("reset_mid_run: product=%h", product);
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    int          bad;
    bad = 0;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      load(a, b);
      start_pp();
      sb.push_back(ref_mul(a, b));
      idle(LAT);
      exp_v = sb.pop_front();
      n_vec++;
      if (product !== exp_v) begin
        n_miss++; bad++;
        if (bad <= 10)
          $display("FAIL random[%0d] A=%h B=%h: got %h expected %h", i, a, b, product, exp_v);
      end
    end
    $display("random: 1000 signed pairs checked");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation watchdog expired");
  end

  initial begin
    reset = 1'b1; ld = 1'b0; ld_PP = 1'b0; in_A = '0; in_B = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_directed();
    test_abort();
    test_ld_and_pp();
    test_pp_in_run();
    test_restart_done();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
